// File: rtl/core_pkg.sv
// Shared types and constants for the front-end.
//   instr_t        32-bit instruction word
//   pc_t           byte-address program counter (PC_W bits)
//   fetch_entry_t  {instr, pc} pair held in the fetch queue
//   imem_image()   instruction memory contents, word index -> word
package core_pkg;

  localparam int unsigned PC_W       = 9;
  localparam int unsigned IMEM_DEPTH = 128;
  localparam int unsigned IMEM_AW    = PC_W - 2;

  typedef logic [31:0]     instr_t;
  typedef logic [PC_W-1:0] pc_t;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_entry_t;

  localparam pc_t    RESET_PC = '0;
  localparam instr_t NOP      = 32'h0000_0013;

  // ROM image: word k holds the value k, which makes every fetched word identify its own
  // address.
  function automatic instr_t imem_image(logic [IMEM_AW-1:0] idx);
    return instr_t'(idx);
  endfunction

endpackage

// File: rtl/imem_rom.sv
// Synchronous-read instruction ROM, one 32-bit word per PC_W-2 bit word index.
//   clk     clock
//   rst_n   asynchronous active-low reset (clears the output register)
//   re_i    read enable; data_o updates on the next rising edge only when set
//   addr_i  word index
//   data_o  registered read data
module imem_rom
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               re_i,
  input  logic [IMEM_AW-1:0] addr_i,
  output instr_t             data_o
);

  instr_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (re_i) begin
      data_q <= imem_image(addr_i);
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem_rom, buffers returned words in a small
// circular queue and presents them to decode over a valid/ready link.
//   clk             clock
//   rst_n           asynchronous active-low reset
//   i_ready         decoder can accept this cycle
//   o_valid         o_instruction/o_pc valid
//   o_instruction   head-of-queue instruction (0 when queue empty)
//   o_pc            head-of-queue byte address (0 when queue empty)
//   redirect_valid  flush everything and restart fetch at redirect_pc
//   redirect_pc     new fetch PC, low two bits ignored
module fetch_unit
  import core_pkg::*;
#(
  parameter pc_t         RESET_PC = core_pkg::RESET_PC,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_ready,
  output logic   o_valid,
  output instr_t o_instruction,
  output pc_t    o_pc,
  input  logic   redirect_valid,
  input  pc_t    redirect_pc
);

  localparam int unsigned PtrW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

  pc_t             pc_q, pc_d;
  logic            inflight_q, inflight_d;
  pc_t             inflight_pc_q, inflight_pc_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  fetch_entry_t    fq_q [FQ_DEPTH];

  instr_t      rom_data;
  logic        issue, push, pop, not_empty;
  int unsigned occupancy;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(FQ_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  imem_rom u_imem_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .re_i   (issue),
    .addr_i (pc_q[PC_W-1:2]),
    .data_o (rom_data)
  );

  assign not_empty     = (count_q != '0);
  assign o_valid       = not_empty && !redirect_valid;
  assign o_instruction = not_empty ? fq_q[head_q].instr : '0;
  assign o_pc          = not_empty ? fq_q[head_q].pc : '0;
  assign pop           = o_valid && i_ready;
  // A redirect kills the word returning this cycle.
  assign push          = inflight_q && !redirect_valid;

  // Reserve a queue slot for every outstanding read so a returning word always has room.
  always_comb begin
    occupancy = 32'(count_q) + 32'(inflight_q) - 32'(pop);
    issue     = !redirect_valid && (occupancy < FQ_DEPTH);
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[PC_W-1:2], 2'b00};
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        pc_d = pc_q + PC_W'(4);
      end
      if (push) begin
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Queue storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_q[tail_q] <= '{instr: rom_data, pc: inflight_pc_q};
    end
  end

endmodule
